// File: rtl/alu_issue_unit.sv
// Sequential issue unit that registers a decoded operation into an external combinational ALU and captures its outputs.
// Latency: rsp_valid rises WAIT_CYC cycles after the request-accept edge; request spacing is WAIT_CYC+2 with rsp_ready high.
// Backpressure: requests stall (req_ready=0) while executing or while a response waits for rsp_ready; rsp_* hold until accepted.
//
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   req_valid_i/req_ready_o     request handshake; req_op_i, req_a_i, req_b_i carry the operation
//   alu_a_o, alu_b_o, alu_c_o,  registered operands and decoded controls driving the ALU
//   alu_invert_o, alu_operacion_o
//   alu_resultado_i, alu_c_i    ALU result and carry-out
//   rsp_valid_o/rsp_ready_i     response handshake; rsp_result_o, rsp_carry_o, rsp_zero_o carry the captured values
//   busy_o                      high while executing or holding a response
//   ops_count_o                 completed-response counter, wraps
module alu_issue_unit #(
  parameter int N        = 4,
  parameter int WAIT_CYC = 1,   // legal range 1..15, fits the 4-bit wait counter
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [N-1:0]     req_a_i,
  input  logic [N-1:0]     req_b_i,
  output logic [N-1:0]     alu_a_o,
  output logic [N-1:0]     alu_b_o,
  output logic             alu_c_o,
  output logic             alu_invert_o,
  output logic [3:0]       alu_operacion_o,
  input  logic [N-1:0]     alu_resultado_i,
  input  logic             alu_c_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [N-1:0]     rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] ops_count_o
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;

  logic       accept;
  logic       capture;
  logic       rsp_done;

  logic [3:0] dec_operacion;
  logic       dec_invert;
  logic       dec_c;

  assign accept   = (state == IDLE) && req_valid_i;
  assign capture  = (state == EXEC) && (wait_cnt == 4'd0);
  assign rsp_done = (state == RESP) && rsp_ready_i;

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Opcode to ALU control. SUB and SLT both run the adder as a + ~b + 1.
  always_comb begin
    dec_operacion = 4'b0000;
    dec_invert    = 1'b0;
    dec_c         = 1'b0;
    case (req_op_i)
      3'd0: dec_operacion = 4'b0000;
      3'd1: dec_operacion = 4'b0001;
      3'd2: dec_operacion = 4'b0010;
      3'd3: begin
        dec_operacion = 4'b0010;
        dec_invert    = 1'b1;
        dec_c         = 1'b1;
      end
      3'd4: begin
        dec_operacion = 4'b0011;
        dec_invert    = 1'b1;
        dec_c         = 1'b1;
      end
      3'd5: dec_operacion = 4'b0110;
      3'd6: dec_operacion = 4'b0111;
      3'd7: dec_operacion = 4'b1000;
      default: dec_operacion = 4'b0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid_i) state_nxt = EXEC;
      EXEC: if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wait_cnt        <= 4'd0;
      alu_a_o         <= '0;
      alu_b_o         <= '0;
      alu_c_o         <= 1'b0;
      alu_invert_o    <= 1'b0;
      alu_operacion_o <= 4'b0000;
      rsp_valid_o     <= 1'b0;
      rsp_result_o    <= '0;
      rsp_carry_o     <= 1'b0;
      rsp_zero_o      <= 1'b0;
      ops_count_o     <= '0;
    end else begin
      // ALU inputs only move on accept, so the path into the ALU is
      // quiet for the whole hold window.
      if (accept) begin
        alu_a_o         <= req_a_i;
        alu_b_o         <= req_b_i;
        alu_c_o         <= dec_c;
        alu_invert_o    <= dec_invert;
        alu_operacion_o <= dec_operacion;
        wait_cnt        <= WAIT_LD;
      end else if ((state == EXEC) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Zero is derived here from the captured result rather than
      // trusting the ALU's own flag.
      if (capture) begin
        rsp_valid_o  <= 1'b1;
        rsp_result_o <= alu_resultado_i;
        rsp_carry_o  <= alu_c_i;
        rsp_zero_o   <= ~(|alu_resultado_i);
      end else if (rsp_done) begin
        rsp_valid_o <= 1'b0;
        ops_count_o <= ops_count_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // main instance: N=4, WAIT_CYC=2, CNT_W=16
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_a, req_b;
  logic [3:0]  alu_a, alu_b, alu_op, alu_res;
  logic        alu_c, alu_inv, alu_co;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
  logic [3:0]  rsp_result;
  logic [15:0] ops_count;

  // wrap instance: N=4, WAIT_CYC=2, CNT_W=2
  logic        w_req_valid, w_req_ready;
  logic [2:0]  w_req_op;
  logic [3:0]  w_req_a, w_req_b;
  logic [3:0]  w_alu_a, w_alu_b, w_alu_op, w_alu_res;
  logic        w_alu_c, w_alu_inv, w_alu_co;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_carry, w_rsp_zero, w_busy;
  logic [3:0]  w_rsp_result;
  logic [1:0]  w_ops_count;

  int checks = 0;
  int failures = 0;
  int exp_ops = 0;

  // Behavioural stand-in for the external 4-bit ALU: {carry, result}.
  function automatic logic [4:0] alu_f(input logic [3:0] sel, input logic inv, input logic cin,
                                       input logic [3:0] a, input logic [3:0] b);
    logic [3:0] bb;
    logic [4:0] s;
    logic [4:0] r;
    bb = inv ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {4'b0000, cin};
    r  = 5'b00000;
    case (sel)
      4'b0000: r = {1'b0, a & bb};
      4'b0001: r = {1'b0, a | bb};
      4'b0010: r = s;
      4'b0011: r = {s[4], 3'b000, ($signed(a) < $signed(b))};
      4'b0110: r = {1'b0, a >> b};
      4'b0111: r = {1'b0, a << b};
      4'b1000: r = {1'b0, 4'($signed(a) >>> b)};
      default: r = 5'b00000;
    endcase
    return r;
  endfunction

  always_comb {alu_co, alu_res}     = alu_f(alu_op, alu_inv, alu_c, alu_a, alu_b);
  always_comb {w_alu_co, w_alu_res} = alu_f(w_alu_op, w_alu_inv, w_alu_c, w_alu_a, w_alu_b);

  alu_issue_unit #(.N(4), .WAIT_CYC(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_o(alu_c),
    .alu_invert_o(alu_inv), .alu_operacion_o(alu_op),
    .alu_resultado_i(alu_res), .alu_c_i(alu_co),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_carry_o(rsp_carry), .rsp_zero_o(rsp_zero),
    .busy_o(busy), .ops_count_o(ops_count)
  );

  alu_issue_unit #(.N(4), .WAIT_CYC(2), .CNT_W(2)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
    .req_op_i(w_req_op), .req_a_i(w_req_a), .req_b_i(w_req_b),
    .alu_a_o(w_alu_a), .alu_b_o(w_alu_b), .alu_c_o(w_alu_c),
    .alu_invert_o(w_alu_inv), .alu_operacion_o(w_alu_op),
    .alu_resultado_i(w_alu_res), .alu_c_i(w_alu_co),
    .rsp_valid_o(w_rsp_valid), .rsp_ready_i(w_rsp_ready),
    .rsp_result_o(w_rsp_result), .rsp_carry_o(w_rsp_carry), .rsp_zero_o(w_rsp_zero),
    .busy_o(w_busy), .ops_count_o(w_ops_count)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Issue one request, wait for its response, check it, then complete the handshake.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] e_sel, input logic e_inv, input logic e_c,
                        input logic [3:0] e_res, input logic e_cy, input logic e_z);
    int k;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_sel"},   int'(alu_op), int'(e_sel));
    chk({nm, "_inv"},   int'(alu_inv), int'(e_inv));
    chk({nm, "_cin"},   int'(alu_c), int'(e_c));
    chk({nm, "_alu_a"}, int'(alu_a), int'(a));
    chk({nm, "_alu_b"}, int'(alu_b), int'(b));
    chk({nm, "_busy"},  int'(busy), 1);
    chk({nm, "_rdy"},   int'(req_ready), 0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, 2);
    chk({nm, "_result"},  int'(rsp_result), int'(e_res));
    chk({nm, "_carry"},   int'(rsp_carry), int'(e_cy));
    chk({nm, "_zero"},    int'(rsp_zero), int'(e_z));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    chk({nm, "_vld_drop"}, int'(rsp_valid), 0);
    chk({nm, "_ops"},      int'(ops_count), exp_ops);
    chk({nm, "_idle_rdy"}, int'(req_ready), 1);
    chk({nm, "_sel_hold"}, int'(alu_op), int'(e_sel));
    chk({nm, "_res_hold"}, int'(rsp_result), int'(e_res));
  endtask

  initial begin
    int k;
    int t;
    int t_prev;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_a = 4'd0; req_b = 4'd0; rsp_ready = 1'b0;
    w_req_valid = 1'b0; w_req_op = 3'd2; w_req_a = 4'd1; w_req_b = 4'd1; w_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_vld",   int'(rsp_valid), 0);
    chk("rst_ops",   int'(ops_count), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_busy",  int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy",   int'(req_ready), 1);

    //       name   op    a      b      sel      inv   c     res    cy    z
    run_op("add",  3'd2, 4'd5, 4'd3, 4'b0010, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    run_op("sub",  3'd3, 4'd3, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    run_op("slt",  3'd4, 4'd2, 4'd5, 4'b0011, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    run_op("sll",  3'd6, 4'd1, 4'd2, 4'b0111, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);
    run_op("and",  3'd0, 4'hC, 4'hA, 4'b0000, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0);
    run_op("or",   3'd1, 4'hC, 4'hA, 4'b0001, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0);
    run_op("srl",  3'd5, 4'h8, 4'd1, 4'b0110, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
    run_op("sra",  3'd7, 4'h8, 4'd1, 4'b1000, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0);
    run_op("addov",3'd2, 4'hF, 4'd1, 4'b0010, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

    // Backpressure: OR 3|4=7 held for 5 cycles while AND F&6 waits at the input.
    req_valid = 1'b1; req_op = 3'd1; req_a = 4'd3; req_b = 4'd4;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_latency", k, 2);
    req_valid = 1'b1; req_op = 3'd0; req_a = 4'hF; req_b = 4'h6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld",    int'(rsp_valid), 1);
      chk("bp_result", int'(rsp_result), 7);
      chk("bp_rdy",    int'(req_ready), 0);
      chk("bp_alu_a",  int'(alu_a), 3);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    chk("bp_vld_drop", int'(rsp_valid), 0);
    chk("bp_idle",     int'(req_ready), 1);
    chk("bp_ops",      int'(ops_count), exp_ops);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp2_busy",  int'(busy), 1);
    chk("bp2_alu_a", int'(alu_a), 15);
    chk("bp2_sel",   int'(alu_op), 0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp2_latency", k, 2);
    chk("bp2_result",  int'(rsp_result), 6);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    chk("bp2_ops", int'(ops_count), exp_ops);

    // Reset one cycle after accept: aborts EXEC, no response, everything cleared.
    req_valid = 1'b1; req_op = 3'd2; req_a = 4'd5; req_b = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rx_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rx_busy",   int'(busy), 0);
    chk("rx_rdy",    int'(req_ready), 1);
    chk("rx_alu_a",  int'(alu_a), 0);
    chk("rx_alu_b",  int'(alu_b), 0);
    chk("rx_sel",    int'(alu_op), 0);
    chk("rx_vld",    int'(rsp_valid), 0);
    chk("rx_result", int'(rsp_result), 0);
    chk("rx_ops",    int'(ops_count), 0);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    chk("rx_no_rsp", k, 0);
    chk("rx_ops_after", int'(ops_count), 0);

    // Counter wrap on the CNT_W=2 instance, request held high, rsp_ready tied high.
    w_req_valid = 1'b1;
    t = 0;
    t_prev = 0;
    for (int i = 1; i <= 5; i++) begin
      k = 0;
      while (!w_rsp_valid && k < 20) begin
        @(negedge clk);
        k++;
        t++;
      end
      chk("wrap_rsp", int'(w_rsp_valid), 1);
      chk("wrap_result", int'(w_rsp_result), 2);
      if (i > 1) chk("wrap_spacing", t - t_prev, 4);
      t_prev = t;
      @(negedge clk);
      t++;
      chk("wrap_ops", int'(w_ops_count), i % 4);
    end
    w_req_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential initiator that drives the team's combinational N-bit ALU. It accepts operation requests over a valid/ready handshake and decodes them into ALU control (operacion, invert, carry-in).
- It holds registered operands stable for a programmable number of cycles, a multicycle-path allowance used for frequency characterisation. It then captures result, carry and a locally computed zero flag.
- The captured values are presented on a valid/ready response port.
- Sits between the processor datapath or test harness and the ALU; the ALU instance itself is external.

Parameters:
- N, 4, operand/result width; must match the ALU instance.
- WAIT_CYC, 1, cycles the ALU inputs are held before capture; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_op_i  in  3  operation code.
- req_a_i  in  N  operand A.
- req_b_i  in  N  operand B / shift amount.
- alu_a_o  out  N  registered operand A to ALU.
- alu_b_o  out  N  registered operand B to ALU.
- alu_c_o  out  1  ALU carry-in.
- alu_invert_o  out  1  ALU B-invert.
- alu_operacion_o  out  4  ALU operation select.
- alu_resultado_i  in  N  ALU result.
- alu_c_i  in  1  ALU carry-out.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted by consumer.
- rsp_result_o  out  N  captured result.
- rsp_carry_o  out  1  captured carry-out.
- rsp_zero_o  out  1  1 when captured result is all zeros.
- busy_o  out  1  1 in EXEC or RESP.
- ops_count_o  out  CNT_W  number of completed responses.

Behaviour:
- Reset is synchronous and active-low: when rst_n_i=0 at a rising edge, the unit enters IDLE. All registered outputs reset to 0, including alu_*, rsp_*, ops_count_o and the wait counter. req_ready_o=1 in the first cycle after reset deasserts. Reset aborts any in-flight EXEC or RESP without producing a response.
- Opcode decode. Format: op -> operacion / invert / c.
  - 0 AND -> 0000/0/0
  - 1 OR -> 0001/0/0
  - 2 ADD -> 0010/0/0
  - 3 SUB -> 0010/1/1
  - 4 SLT -> 0011/1/1
  - 5 SRL -> 0110/0/0
  - 6 SLL -> 0111/0/0
  - 7 SRA -> 1000/0/0
  - The code space is fully used; there is no illegal op.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i=1: register operands and decoded controls into alu_* outputs, load wait counter with WAIT_CYC-1, go to EXEC.
- EXEC:
  - req_ready_o=0; alu_* outputs held constant.
  - Counter decrements each cycle.
  - When counter=0 at a rising edge: capture alu_resultado_i into rsp_result_o and alu_c_i into rsp_carry_o. Set rsp_zero_o = NOR of alu_resultado_i; the ALU's own zero flag is not used. Set rsp_valid_o=1 and go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid_o=1 and rsp_ready_i=0.
  - On rsp_ready_i=1: rsp_valid_o drops at that edge, ops_count_o increments (wraps modulo 2^CNT_W), go to IDLE.
  - rsp_result_o, rsp_carry_o and rsp_zero_o retain their values after the handshake.
  - req_valid_i is ignored in RESP.
- Latency:
  - rsp_valid_o rises exactly WAIT_CYC cycles after the request-accept edge.
  - Minimum request-to-request spacing is WAIT_CYC+2 cycles with rsp_ready_i tied high.
- alu_* outputs retain their last values in IDLE and RESP. They change only on request accept or reset.
- Shift amount is the full N-bit B operand; behaviour for B≥N is whatever the ALU returns, and it is captured unmodified.
- busy_o = (state != IDLE); req_ready_o = (state == IDLE). Both are combinational from the state register.

Test Plan:
(All scenarios: N=4, WAIT_CYC=2, the team's N-bit ALU connected to alu_* ports.)
- ADD, a=5, b=3 -> alu_operacion_o=0010, invert=0, c=0; rsp_valid_o rises 2 cycles after accept with result=8, carry=0, zero=0; ops_count_o=1 after handshake.
- SUB, a=3, b=3 -> invert=1, c=1; result=0, carry=1, zero=1.
- SLT, a=2, b=5 -> operacion=0011; result=1, zero=0. Then SLL, a=1, b=2 -> operacion=0111, result=4.
- Backpressure: rsp_ready_i low for 5 cycles after rsp_valid_o -> rsp_* stable, req_ready_o=0, a second req_valid_i is not accepted. Raise rsp_ready_i -> back to IDLE next cycle and the second request is accepted.
- Reset mid-EXEC: rst_n_i=0 one cycle after accept -> next edge state IDLE, all outputs 0, no response, ops_count_o unchanged at 0.
- Counter wrap: CNT_W=2, complete 5 operations back-to-back with rsp_ready_i=1 -> ops_count_o sequence 1,2,3,0,1; request spacing exactly 4 cycles.
